// File: rtl/harris_response.sv
`default_nettype none
// ============================================================================
// Module   : harris_response
// Function : 6-stage pipelined Harris corner response, one 6x6 window per clock.
//            Optional per-frame corner counter when HARRIS_CORNER_COUNT_EN is defined.
// Revision : 1.0
// ============================================================================
module harris_response #(
  parameter int IMG_WIDTH = 512,
  parameter int WIN_ROWS  = 507,
  parameter int K_NUM     = 1,
  parameter int K_SHIFT   = 4,
  parameter int RESP_W    = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [0:5][0:5][7:0]     window,
  input  logic                     window_valid,
  input  logic signed [RESP_W-1:0] threshold,
  output logic signed [RESP_W-1:0] response,
  output logic                     corner,
  output logic                     resp_valid,
  output logic [8:0]               out_col,
  output logic [8:0]               out_row,
  output logic                     frame_done,
  output logic [31:0]              corner_count
);

  localparam int                     c_PW       = ((RESP_W > 52) ? RESP_W : 52) + K_SHIFT + 2;
  localparam logic [8:0]             c_COL_LAST = 9'(IMG_WIDTH - 1);
  localparam logic [8:0]             c_ROW_LAST = 9'(WIN_ROWS - 1);
  localparam logic signed [c_PW-1:0] c_K        = c_PW'(K_NUM);

  logic [8:0]         r_col_cnt;
  logic [8:0]         r_row_cnt;
  logic [4:0]         r_vld;
  logic [8:0]         r_col [5];
  logic [8:0]         r_row [5];
  logic signed [8:0]  r_ix  [16];
  logic signed [8:0]  r_iy  [16];
  logic [15:0]        r_ixx [16];
  logic [15:0]        r_iyy [16];
  logic signed [16:0] r_ixy [16];
  logic [17:0]        r_pxx [4];
  logic [17:0]        r_pyy [4];
  logic signed [18:0] r_pxy [4];
  logic [20:0]        r_sxx;
  logic [20:0]        r_syy;
  logic signed [20:0] r_sxy;
  logic signed [51:0] r_det;
  logic signed [51:0] r_tr2;

  logic signed [51:0]       w_sxx_s;
  logic signed [51:0]       w_syy_s;
  logic signed [51:0]       w_sxy_s;
  logic signed [51:0]       w_tr;
  logic signed [c_PW-1:0]   w_full;
  logic signed [RESP_W-1:0] w_resp;
  logic                     w_corner;
  logic                     w_unused;

  // The four window corners never enter a central difference.
  assign w_unused = ^{window[0][0], window[0][5], window[5][0], window[5][5]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_vld     <= '0;
    end else begin
      r_vld <= {r_vld[3:0], window_valid};
      if (window_valid) begin
        if (r_col_cnt == c_COL_LAST) begin
          r_col_cnt <= '0;
          r_row_cnt <= (r_row_cnt == c_ROW_LAST) ? 9'd0 : r_row_cnt + 9'd1;
        end else begin
          r_col_cnt <= r_col_cnt + 9'd1;
        end
      end
    end
  end

  // Data path carries no reset; in-flight data is discarded through the valid chain.
  always_ff @(posedge clk) begin
    r_col[0] <= r_col_cnt;
    r_row[0] <= r_row_cnt;
    for (int s = 1; s < 5; s++) begin
      r_col[s] <= r_col[s-1];
      r_row[s] <= r_row[s-1];
    end
  end

  for (genvar r = 1; r < 5; r++) begin : g_grad_row
    for (genvar c = 1; c < 5; c++) begin : g_grad_col
      localparam int c_P = (r - 1) * 4 + (c - 1);
      always_ff @(posedge clk) begin
        r_ix[c_P] <= $signed({1'b0, window[r][c+1]}) - $signed({1'b0, window[r][c-1]});
        r_iy[c_P] <= $signed({1'b0, window[r+1][c]}) - $signed({1'b0, window[r-1][c]});
      end
    end
  end

  for (genvar p = 0; p < 16; p++) begin : g_prod
    always_ff @(posedge clk) begin
      r_ixx[p] <= 16'(r_ix[p]) * 16'(r_ix[p]);
      r_iyy[p] <= 16'(r_iy[p]) * 16'(r_iy[p]);
      r_ixy[p] <= 17'(r_ix[p]) * 17'(r_iy[p]);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_part
    always_ff @(posedge clk) begin
      r_pxx[g] <= 18'(r_ixx[4*g]) + 18'(r_ixx[4*g+1]) + 18'(r_ixx[4*g+2]) + 18'(r_ixx[4*g+3]);
      r_pyy[g] <= 18'(r_iyy[4*g]) + 18'(r_iyy[4*g+1]) + 18'(r_iyy[4*g+2]) + 18'(r_iyy[4*g+3]);
      r_pxy[g] <= 19'(r_ixy[4*g]) + 19'(r_ixy[4*g+1]) + 19'(r_ixy[4*g+2]) + 19'(r_ixy[4*g+3]);
    end
  end

  assign w_sxx_s = 52'(r_sxx);
  assign w_syy_s = 52'(r_syy);
  assign w_sxy_s = 52'(r_sxy);
  assign w_tr    = w_sxx_s + w_syy_s;

  always_ff @(posedge clk) begin
    r_sxx <= 21'(r_pxx[0]) + 21'(r_pxx[1]) + 21'(r_pxx[2]) + 21'(r_pxx[3]);
    r_syy <= 21'(r_pyy[0]) + 21'(r_pyy[1]) + 21'(r_pyy[2]) + 21'(r_pyy[3]);
    r_sxy <= 21'(r_pxy[0]) + 21'(r_pxy[1]) + 21'(r_pxy[2]) + 21'(r_pxy[3]);
    r_det <= w_sxx_s * w_syy_s - w_sxy_s * w_sxy_s;
    r_tr2 <= w_tr * w_tr;
  end

  // Arithmetic shift floors toward -inf; full width keeps k*trace^2 exact before truncation.
  assign w_full   = c_PW'(r_det) - ((c_PW'(r_tr2) * c_K) >>> K_SHIFT);
  assign w_resp   = w_full[RESP_W-1:0];
  assign w_corner = (w_resp > threshold);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      response   <= '0;
      corner     <= 1'b0;
      resp_valid <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      resp_valid <= r_vld[4];
      corner     <= r_vld[4] & w_corner;
      frame_done <= r_vld[4] && (r_col[4] == c_COL_LAST) && (r_row[4] == c_ROW_LAST);
      if (r_vld[4]) begin
        response <= w_resp;
        out_col  <= r_col[4];
        out_row  <= r_row[4];
      end
    end
  end

`ifdef HARRIS_CORNER_COUNT_EN
  logic [31:0] r_acc;
  logic [31:0] w_acc_inc;

  // A corner arriving with frame_done belongs to the finishing frame.
  assign w_acc_inc = (resp_valid && corner && (r_acc != 32'hFFFF_FFFF)) ? r_acc + 32'd1 : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc        <= '0;
      corner_count <= '0;
    end else if (frame_done) begin
      corner_count <= w_acc_inc;
      r_acc        <= '0;
    end else begin
      r_acc <= w_acc_inc;
    end
  end
`else
  assign corner_count = '0;
`endif

endmodule
`default_nettype wire
